// File: rtl/cdb_types.sv
// Shared CDB arbitration constants and the broadcast packet layout.
// Consumers of the CDB decode broadcasts through cdb_pkt_t.
package cdb_types;

    localparam int CDB_NUM_REQ      = 4;
    localparam int CDB_STARVE_LIMIT = 8;
    localparam int FIFO_DWIDTH      = 32;
    localparam int CDB_SRC_W        = $clog2(CDB_NUM_REQ);

    typedef struct packed {
        logic                 valid;
        logic [CDB_SRC_W-1:0] src;
        logic [FIFO_DWIDTH-1:0] data;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_pick.sv
// Winner select: forced (starving) requester, then priority requester 0, then round-robin from ptr.
// Latency: purely combinational.
// Backpressure: none here; the caller masks req to stall.
module rr_pick #(
    parameter  int N     = 4,
    localparam int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic [N-1:0]     force_mask,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && force_mask[i] && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!found && req[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
        // Rotation covers indices 1..N-1 only, starting at ptr.
        for (int k = 0; k < N - 1; k++) begin
            idx = PTR_W'((int'(ptr) - 1 + k) % (N - 1) + 1);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: dequeues one result FIFO per cycle and broadcasts it.
// Latency: grant is combinational; broadcast is registered, one cycle after the grant.
// Backpressure: cdb_ready low or flush suppresses all grants; starve counters hold while stalled.
module cdb_arbiter #(
    parameter  int CDB_NUM_REQ      = cdb_types::CDB_NUM_REQ,
    parameter  int CDB_STARVE_LIMIT = cdb_types::CDB_STARVE_LIMIT,
    parameter  int FIFO_DWIDTH      = cdb_types::FIFO_DWIDTH,
    localparam int SRC_W            = $clog2(CDB_NUM_REQ),
    localparam int CNT_W            = $clog2(CDB_STARVE_LIMIT + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [CDB_NUM_REQ-1:0]                  req,
    input  logic [CDB_NUM_REQ-1:0][FIFO_DWIDTH-1:0] din,
    output logic [CDB_NUM_REQ-1:0]                  grant,
    input  logic                                    cdb_ready,
    output logic                                    cdb_valid,
    output logic [FIFO_DWIDTH-1:0]                  cdb_data,
    output logic [SRC_W-1:0]                        cdb_src
);

    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       ptr_nxt;
    logic [CNT_W-1:0]       starve_cnt [1:CDB_NUM_REQ-1];
    logic [CDB_NUM_REQ-1:0] force_mask;
    logic [CDB_NUM_REQ-1:0] req_en;
    logic                   arb_en;
    logic [SRC_W-1:0]       win_idx;
    logic [FIFO_DWIDTH-1:0] win_dat;

    // rst gates grants so no FIFO is popped while the bus is held in reset.
    assign arb_en = rst && cdb_ready && !flush;
    assign req_en = req & {CDB_NUM_REQ{arb_en}};

    always_comb begin
        force_mask = '0;
        for (int i = 1; i < CDB_NUM_REQ; i++) begin
            force_mask[i] = (starve_cnt[i] == CNT_W'(CDB_STARVE_LIMIT));
        end
    end

    rr_pick #(
        .N (CDB_NUM_REQ)
    ) u_rr_pick (
        .req        (req_en),
        .ptr        (rr_ptr),
        .force_mask (force_mask),
        .grant      (grant)
    );

    always_comb begin
        win_idx = '0;
        win_dat = '0;
        ptr_nxt = rr_ptr;
        for (int i = 0; i < CDB_NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx = SRC_W'(i);
                win_dat = din[i];
                if (i != 0) begin
                    ptr_nxt = (i == CDB_NUM_REQ - 1) ? SRC_W'(1) : SRC_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= SRC_W'(1);
            for (int i = 1; i < CDB_NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else if (flush) begin
            cdb_valid <= 1'b0;
            rr_ptr    <= SRC_W'(1);
            for (int i = 1; i < CDB_NUM_REQ; i++) begin
                starve_cnt[i] <= '0;
            end
        end else begin
            cdb_valid <= |grant;
            if (|grant) begin
                cdb_data <= win_dat;
                cdb_src  <= win_idx;
                rr_ptr   <= ptr_nxt;
            end
            if (cdb_ready) begin
                for (int i = 1; i < CDB_NUM_REQ; i++) begin
                    if (grant[i] || !req[i]) begin
                        starve_cnt[i] <= '0;
                    end else if (starve_cnt[i] != CNT_W'(CDB_STARVE_LIMIT)) begin
                        starve_cnt[i] <= starve_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: per-cycle input/expected-grant table plus an async reset sequence.
module tb_cdb_arbiter;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [3:0]       req;
    logic [3:0][31:0] din;
    logic [3:0]       grant;
    logic             cdb_ready;
    logic             cdb_valid;
    logic [31:0]      cdb_data;
    logic [1:0]       cdb_src;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       flush;
        logic [3:0] req;
        logic       ready;
        logic [3:0] exp_grant;
    } vec_t;

    vec_t vecs[$];

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req       (req),
        .din       (din),
        .grant     (grant),
        .cdb_ready (cdb_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] din_val(input int v, input int i);
        return 32'(32'hC0DE_0000 | (v << 8) | i);
    endfunction

    task automatic set_din(input int v);
        for (int i = 0; i < 4; i++) din[i] = din_val(v, i);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic f, input logic [3:0] r, input logic rdy, input logic [3:0] g, input int reps);
        vec_t e;
        e.flush = f; e.req = r; e.ready = rdy; e.exp_grant = g;
        for (int k = 0; k < reps; k++) vecs.push_back(e);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic [1:0]  exp_src;

        rst = 1'b0; flush = 1'b0; req = 4'b1111; cdb_ready = 1'b1; set_din(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_data",  cdb_data, 32'd0);
        check("rst_src",   32'(cdb_src), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);

        // Round robin over 1..3 from a fresh pointer.
        add(0, 4'b1110, 1, 4'b0010, 1);
        add(0, 4'b1110, 1, 4'b0100, 1);
        add(0, 4'b1110, 1, 4'b1000, 1);
        add(0, 4'b0000, 1, 4'b0000, 1);
        // Requester 0 wins until requester 1 starves to the limit.
        add(0, 4'b0011, 1, 4'b0001, 8);
        add(0, 4'b0011, 1, 4'b0010, 1);
        add(0, 4'b0011, 1, 4'b0001, 7);
        // Stall with counter 1 one short of the limit; it must not advance.
        add(0, 4'b1011, 0, 4'b0000, 5);
        add(0, 4'b1011, 1, 4'b0001, 1);
        add(0, 4'b1011, 1, 4'b0010, 1);
        // Flush resets the pointer to 1 (otherwise it would sit at 2).
        add(1, 4'b0110, 1, 4'b0000, 1);
        add(0, 4'b0110, 1, 4'b0010, 1);
        // Pointer at 3 wraps to 1.
        add(0, 4'b0100, 1, 4'b0100, 1);
        add(0, 4'b0110, 1, 4'b0010, 1);
        add(0, 4'b0110, 1, 4'b0100, 1);
        add(0, 4'b1111, 0, 4'b0000, 1);

        @(negedge clk);
        rst = 1'b1; req = 4'b0000;
        exp_data = '0;
        exp_src  = '0;

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            flush = vecs[v].flush; req = vecs[v].req; cdb_ready = vecs[v].ready;
            set_din(v + 1);
            #2;
            check($sformatf("v%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
            for (int i = 0; i < 4; i++) begin
                if (vecs[v].exp_grant[i]) begin
                    exp_src  = 2'(i);
                    exp_data = din_val(v + 1, i);
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", v), 32'(cdb_valid), 32'(|vecs[v].exp_grant));
            check($sformatf("v%0d_src", v), 32'(cdb_src), 32'(exp_src));
            check($sformatf("v%0d_data", v), cdb_data, exp_data);
        end

        // Reset asserted mid-cycle while a broadcast is live.
        @(negedge clk);
        flush = 1'b0; req = 4'b1110; cdb_ready = 1'b1; set_din(90);
        #2;
        check("pre_rst_grant", 32'(grant), 32'b1000);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(cdb_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(cdb_valid), 32'd0);
        check("async_data",  cdb_data, 32'd0);
        check("async_src",   32'(cdb_src), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        @(negedge clk);
        rst = 1'b1; set_din(91);
        #2;
        check("post_rst_grant", 32'(grant), 32'b0010);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(cdb_valid), 32'd1);
        check("post_rst_src",   32'(cdb_src), 32'd1);
        check("post_rst_data",  cdb_data, din_val(91, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
